// File: rtl/inst_issue_queue.sv
// -----------------------------------------------------------------------------
// inst_issue_queue
//   Encodes instruction requests into {opcode, a, b, c, addr} words, buffers
//   them in a DEPTH-entry FIFO together with a repeat count and address
//   stride, and issues them one word per handshake.  Each entry expands into
//   rep+1 issued words, the addr field advancing by stride (mod 2^ADDR_WIDTH)
//   on every repeat.
//
// Ports
//   clk, rstn          rising-edge clock, asynchronous active-low reset
//   enc_valid/ready    request handshake (ready = FIFO not full and no flush)
//   opcode, a/b/c_index, addr, rep, stride   request fields
//   inst, inst_valid, inst_ready             issued word and its handshake
//   flush              synchronous clear of FIFO and output stage
//   count              FIFO occupancy (output register not included)
//   busy               inst_valid or FIFO not empty
// -----------------------------------------------------------------------------
module inst_issue_queue #(
    parameter int OPCODE_WIDTH = 3,
    parameter int INDEX_WIDTH  = 4,
    parameter int ADDR_WIDTH   = 12,
    parameter int DEPTH        = 8,
    localparam int INST_WIDTH  = OPCODE_WIDTH + 3*INDEX_WIDTH + ADDR_WIDTH,
    localparam int CNT_W       = $clog2(DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    enc_valid,
    output logic                    enc_ready,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic [INDEX_WIDTH-1:0]  a_index,
    input  logic [INDEX_WIDTH-1:0]  b_index,
    input  logic [INDEX_WIDTH-1:0]  c_index,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [3:0]              rep,
    input  logic [ADDR_WIDTH-1:0]   stride,
    output logic [INST_WIDTH-1:0]   inst,
    output logic                    inst_valid,
    input  logic                    inst_ready,
    input  logic                    flush,
    output logic [CNT_W-1:0]        count,
    output logic                    busy
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic {IDLE, ISSUE} state_e;

    // FIFO storage (no reset needed: validity is tracked by count/pointers)
    logic [INST_WIDTH-1:0] word_mem_q   [DEPTH];
    logic [3:0]            rep_mem_q    [DEPTH];
    logic [ADDR_WIDTH-1:0] stride_mem_q [DEPTH];

    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]      count_q, count_d;

    state_e                state_q;
    logic [INST_WIDTH-1:0] inst_q;
    logic [3:0]            rem_q;
    logic [ADDR_WIDTH-1:0] cur_stride_q;

    logic                  push, pop, hs;
    logic [INST_WIDTH-1:0] enc_word, bumped_word;

    assign enc_word  = {opcode, a_index, b_index, c_index, addr};
    assign enc_ready = (count_q != CNT_W'(DEPTH)) && !flush;
    assign push      = enc_valid && enc_ready;
    assign hs        = (state_q == ISSUE) && inst_ready;
    // Head leaves the FIFO when the output stage is empty or its last repeat
    // is being accepted; the latter gives back-to-back issue with no bubble.
    assign pop       = !flush && (count_q != '0) &&
                       ((state_q == IDLE) || (hs && rem_q == 4'd0));

    // Only the addr field advances on a repeat; upper fields are kept.
    assign bumped_word = {inst_q[INST_WIDTH-1:ADDR_WIDTH],
                          inst_q[ADDR_WIDTH-1:0] + cur_stride_q};

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            word_mem_q[wr_ptr_q]   <= enc_word;
            rep_mem_q[wr_ptr_q]    <= rep;
            stride_mem_q[wr_ptr_q] <= stride;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

    // Issue FSM with registered word, repeat counter and stride.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            inst_q       <= '0;
            rem_q        <= '0;
            cur_stride_q <= '0;
        end else if (flush) begin
            state_q      <= IDLE;
            inst_q       <= '0;
            rem_q        <= '0;
            cur_stride_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        state_q      <= ISSUE;
                        inst_q       <= word_mem_q[rd_ptr_q];
                        rem_q        <= rep_mem_q[rd_ptr_q];
                        cur_stride_q <= stride_mem_q[rd_ptr_q];
                    end
                end
                ISSUE: begin
                    if (inst_ready) begin
                        if (rem_q != 4'd0) begin
                            inst_q <= bumped_word;
                            rem_q  <= rem_q - 4'd1;
                        end else if (pop) begin
                            inst_q       <= word_mem_q[rd_ptr_q];
                            rem_q        <= rep_mem_q[rd_ptr_q];
                            cur_stride_q <= stride_mem_q[rd_ptr_q];
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign inst       = inst_q;
    assign inst_valid = (state_q == ISSUE);
    assign count      = count_q;
    assign busy       = inst_valid || (count_q != '0);

endmodule

// File: tb/tb_inst_issue_queue.sv
module tb_inst_issue_queue;
    localparam int OW = 3, IW = 4, AW = 12, DEPTH = 8;
    localparam int W  = OW + 3*IW + AW;
    localparam int CW = $clog2(DEPTH) + 1;

    logic          clk = 1'b0, rstn = 1'b0;
    logic          enc_valid = 1'b0, inst_ready = 1'b0, flush = 1'b0;
    logic [OW-1:0] opcode = '0;
    logic [IW-1:0] a_index = '0, b_index = '0, c_index = '0;
    logic [AW-1:0] addr = '0, stride = '0;
    logic [3:0]    rep = '0;
    logic          enc_ready, inst_valid, busy;
    logic [W-1:0]  inst;
    logic [CW-1:0] count;

    inst_issue_queue #(.OPCODE_WIDTH(OW), .INDEX_WIDTH(IW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rstn(rstn), .enc_valid(enc_valid), .enc_ready(enc_ready),
        .opcode(opcode), .a_index(a_index), .b_index(b_index), .c_index(c_index),
        .addr(addr), .rep(rep), .stride(stride), .inst(inst), .inst_valid(inst_valid),
        .inst_ready(inst_ready), .flush(flush), .count(count), .busy(busy));

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // ---------------- reference model: request queue + expanded word list ----
    typedef struct {
        logic [W-1:0]  word;
        int            rep;
    } ent_t;

    ent_t          m_fifo[$];
    logic [W-1:0]  exp_q[$];
    bit            m_valid = 0, stall_hold = 0, m_hs, m_acc;
    int            m_rem = 0;
    int            hs_cnt = 0, vcyc = 0;
    logic [W-1:0]  last_inst = '0, prev_inst = '0, m_tmp;
    logic [AW-1:0] m_a;
    ent_t          m_e;

    initial forever begin
        @(posedge clk or negedge rstn);
        if (!rstn || flush) begin
            m_fifo.delete();
            exp_q.delete();
            m_valid = 0; m_rem = 0; stall_hold = 0;
        end else begin
            m_acc = enc_valid && (m_fifo.size() != DEPTH);
            m_hs  = m_valid && inst_ready;
            stall_hold = m_valid && !inst_ready;
            if (m_hs && m_rem != 0) m_rem--;
            else if (!m_valid || m_hs) begin
                if (m_fifo.size() > 0) begin
                    m_e = m_fifo.pop_front();
                    m_valid = 1; m_rem = m_e.rep;
                end else m_valid = 0;
            end
            if (m_acc) begin
                m_e.word = {opcode, a_index, b_index, c_index, addr};
                m_e.rep  = int'(rep);
                m_fifo.push_back(m_e);
                m_a = addr;
                for (int k = 0; k <= int'(rep); k++) begin
                    m_tmp = {opcode, a_index, b_index, c_index, m_a};
                    exp_q.push_back(m_tmp);
                    m_a = m_a + stride;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    initial forever begin
        @(negedge clk);
        chk("count", count, m_fifo.size());
        chk("inst_valid", inst_valid, m_valid);
        chk("enc_ready", enc_ready, (m_fifo.size() != DEPTH) && !flush);
        chk("busy", busy, m_valid || (m_fifo.size() != 0));
        if (stall_hold && rstn) chk("stall_stable", inst, prev_inst);
        if (inst_valid) vcyc++;
        if (inst_valid && inst_ready && rstn) begin
            if (exp_q.size() == 0) fail("unexpected_issue");
            else chk("inst", inst, exp_q.pop_front());
            hs_cnt++;
            last_inst = inst;
        end
        prev_inst = inst;
    end

    // ---------------- driver helpers ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic set_req(input logic [OW-1:0] op, input logic [IW-1:0] a, b, c,
                           input logic [AW-1:0] ad, input logic [3:0] r, input logic [AW-1:0] s);
        opcode = op; a_index = a; b_index = b; c_index = c; addr = ad; rep = r; stride = s;
    endtask

    task automatic push_one(input logic [OW-1:0] op, input logic [IW-1:0] a, b, c,
                            input logic [AW-1:0] ad, input logic [3:0] r, input logic [AW-1:0] s);
        bit done;
        done = 0;
        set_req(op, a, b, c, ad, r, s);
        enc_valid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            done = enc_ready;
            tick();
        end
        enc_valid = 1'b0;
        if (!done) fail("push_timeout");
    endtask

    task automatic wait_idle(input int limit);
        bit done;
        done = 0;
        for (int i = 0; i < limit && !done; i++) begin
            if (!busy) done = 1;
            else tick();
        end
        if (!done) fail("idle_timeout");
    endtask

    int h0, v0;

    initial begin
        #2;
        chk("rst_count", count, 0);
        chk("rst_valid", inst_valid, 0);
        chk("rst_inst", inst, 0);
        chk("rst_busy", busy, 0);
        #20;
        @(posedge clk); #1;
        rstn = 1'b1;
        tick();
        chk("ready_after_reset", enc_ready, 1);

        // single encode, minimum latency
        inst_ready = 1'b1;
        h0 = hs_cnt;
        push_one(3'b110, 4'd0, 4'd0, 4'd4, 12'h000, 4'd0, 12'h000);
        chk("latency_not_yet", inst_valid, 0);
        tick();
        chk("latency_valid", inst_valid, 1);
        wait_idle(50);
        chk("enc_issue_count", hs_cnt - h0, 1);
        chk("enc_word", last_inst, 27'h6004000);

        // burst with address wrap
        h0 = hs_cnt; v0 = vcyc;
        push_one(3'd1, 4'd1, 4'd2, 4'd3, 12'hF00, 4'd3, 12'h100);
        wait_idle(50);
        chk("burst_issues", hs_cnt - h0, 4);
        chk("burst_consecutive", vcyc - v0, 4);
        chk("burst_last_addr", last_inst[AW-1:0], 12'h200);

        // fill: first word held, 8 in FIFO, 10th refused
        inst_ready = 1'b0;
        enc_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            set_req(3'd2, 4'(i), 4'd5, 4'd6, 12'(16 * i + 1), 4'd0, 12'd0);
            tick();
        end
        enc_valid = 1'b0;
        chk("full_count", count, 8);
        chk("full_ready", enc_ready, 0);
        chk("full_head", inst, {3'd2, 4'd0, 4'd5, 4'd6, 12'd1});
        h0 = hs_cnt;
        inst_ready = 1'b1;
        wait_idle(100);
        chk("full_drained", hs_cnt - h0, 9);

        // backpressure toggling
        inst_ready = 1'b0;
        h0 = hs_cnt;
        for (int i = 0; i < 3; i++) push_one(3'd5, 4'(i), 4'd1, 4'd1, 12'(i * 7), 4'd0, 12'd0);
        for (int i = 0; i < 40 && busy; i++) begin
            inst_ready = ~inst_ready;
            tick();
        end
        chk("bp_issued", hs_cnt - h0, 3);
        chk("bp_busy_low", busy, 0);

        // flush mid-burst with simultaneous request
        inst_ready = 1'b0;
        push_one(3'd3, 4'd1, 4'd1, 4'd1, 12'h010, 4'd5, 12'h001);
        push_one(3'd4, 4'd2, 4'd2, 4'd2, 12'h020, 4'd0, 12'h000);
        push_one(3'd4, 4'd3, 4'd3, 4'd3, 12'h030, 4'd0, 12'h000);
        h0 = hs_cnt;
        inst_ready = 1'b1;
        tick(); tick();
        set_req(3'd7, 4'd7, 4'd7, 4'd7, 12'h777, 4'd0, 12'd0);
        flush = 1'b1; enc_valid = 1'b1; inst_ready = 1'b0;
        tick();
        flush = 1'b0; enc_valid = 1'b0;
        chk("flush_valid", inst_valid, 0);
        chk("flush_count", count, 0);
        chk("flush_issued", hs_cnt - h0, 2);
        tick();
        chk("flush_push_dropped", busy, 0);

        // asynchronous reset during ISSUE
        push_one(3'd6, 4'd9, 4'd9, 4'd9, 12'h123, 4'd2, 12'h004);
        push_one(3'd6, 4'd8, 4'd8, 4'd8, 12'h456, 4'd2, 12'h004);
        #2 rstn = 1'b0;
        #1;
        chk("arst_valid", inst_valid, 0);
        chk("arst_inst", inst, 0);
        chk("arst_count", count, 0);
        chk("arst_busy", busy, 0);
        @(posedge clk); #1;
        tick();
        rstn = 1'b1;
        tick();
        chk("arst_ready", enc_ready, 1);
        inst_ready = 1'b1;
        h0 = hs_cnt;
        push_one(3'd1, 4'd4, 4'd4, 4'd4, 12'hABC, 4'd0, 12'd0);
        wait_idle(50);
        chk("arst_resume", hs_cnt - h0, 1);

        // randomized traffic
        for (int i = 0; i < 500; i++) begin
            enc_valid  = ($urandom_range(0, 1) == 1);
            set_req(OW'($urandom), IW'($urandom), IW'($urandom), IW'($urandom),
                    AW'($urandom), 4'($urandom_range(0, 3)), AW'($urandom));
            inst_ready = ($urandom_range(0, 9) < 7);
            flush      = ($urandom_range(0, 59) == 0);
            tick();
        end
        flush = 1'b0; enc_valid = 1'b0; inst_ready = 1'b1;
        wait_idle(500);
        tick();
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
